// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, per-scan decode, ghost rejection, debounce.
// Optional auto-repeat of key_valid while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_val,
   output logic       key_valid,
   output logic       key_down
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

   if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_param
      $error("keypad_scanner: parameter out of range");
   end

   logic [3:0]       row_meta_reg, row_sync_reg;
   logic [DIV_W-1:0] div_reg;
   logic [1:0]       col_idx_reg;
   logic [1:0]       acc_cnt_reg;     // hits so far this scan, saturating at 2
   logic [3:0]       acc_code_reg;
   logic [4:0]       prev_res_reg;    // {present, code} of the previous full scan
   logic [STB_W-1:0] stable_cnt_reg;
   logic [3:0]       key_val_reg;
   logic             key_valid_reg, key_down_reg;

   logic [1:0]       col_hits, hit_row, scan_cnt;
   logic [2:0]       hit_sum;
   logic [3:0]       scan_code;
   logic             present, same, accept, div_tick, scan_end;
   logic [4:0]       result;
   logic [STB_W-1:0] stable_next;

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col[gi] = (col_idx_reg != 2'(gi));
   end

   always_comb begin
      col_hits = 2'd0;
      hit_row  = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync_reg[r]) begin
            hit_row = 2'(r);
            if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
         end
      end
      hit_sum     = {1'b0, acc_cnt_reg} + {1'b0, col_hits};
      scan_cnt    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      scan_code   = (col_hits != 2'd0) ? {hit_row, col_idx_reg} : acc_code_reg;
      present     = (scan_cnt == 2'd1);
      result      = {present, present ? scan_code : 4'd0};
      same        = (result == prev_res_reg);
      stable_next = !same ? STB_W'(1) :
                    (stable_cnt_reg == STB_MAX) ? STB_MAX : stable_cnt_reg + STB_W'(1);
      // A change that lands straight on the threshold (DEBOUNCE_SCANS=1) is still a transition
      accept      = (stable_next == STB_MAX) && (!same || stable_cnt_reg != STB_MAX);
      div_tick    = (div_reg == DIV_LAST);
      scan_end    = div_tick && (col_idx_reg == 2'd3);
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS);
   logic [REP_W-1:0] rep_cnt_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta_reg   <= 4'hF;
         row_sync_reg   <= 4'hF;
         div_reg        <= '0;
         col_idx_reg    <= 2'd0;
         acc_cnt_reg    <= 2'd0;
         acc_code_reg   <= 4'd0;
         prev_res_reg   <= 5'd0;
         stable_cnt_reg <= '0;
         key_val_reg    <= 4'd0;
         key_valid_reg  <= 1'b0;
         key_down_reg   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_reg    <= '0;
`endif
      end else begin
         row_meta_reg  <= row;
         row_sync_reg  <= row_meta_reg;
         key_valid_reg <= 1'b0;
         div_reg       <= div_tick ? '0 : div_reg + DIV_W'(1);
         if (div_tick) begin
            col_idx_reg <= col_idx_reg + 2'd1;
            if (!scan_end) begin
               acc_cnt_reg  <= scan_cnt;
               acc_code_reg <= scan_code;
            end else begin
               acc_cnt_reg    <= 2'd0;
               acc_code_reg   <= 4'd0;
               prev_res_reg   <= result;
               stable_cnt_reg <= stable_next;
               if (accept) begin
                  if (present && (!key_down_reg || scan_code != key_val_reg)) begin
                     key_val_reg   <= scan_code;
                     key_down_reg  <= 1'b1;
                     key_valid_reg <= 1'b1;
                  end else if (!present) begin
                     key_down_reg  <= 1'b0;
                  end
               end
`ifdef KEYPAD_REPEAT_EN
               if (accept) begin
                  rep_cnt_reg <= '0;
               end else if (key_down_reg && same && present) begin
                  if (rep_cnt_reg + REP_W'(1) == REP_LAST) begin
                     rep_cnt_reg   <= '0;
                     key_valid_reg <= 1'b1;
                  end else begin
                     rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
                  end
               end else begin
                  rep_cnt_reg <= '0;
               end
`endif
            end
         end
      end
   end

   assign key_val   = key_val_reg;
   assign key_valid = key_valid_reg;
   assign key_down  = key_down_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad model drives rows from col, scoreboard checks key_valid pulses.
// Defining KEYPAD_REPEAT_EN here and in the design adds the auto-repeat checks.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row, col, key_val;
   logic        key_valid, key_down;
   logic [15:0] pressed = 16'h0000;
   int          total = 0;
   int          bad = 0;
   logic [3:0]  exp_q[$];
   logic [4:0]  mon_exp;
   logic [3:0]  col_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_SCANS(4)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .key_val(key_val), .key_valid(key_valid), .key_down(key_down)
   );

   // Keypad model: a pressed key pulls its row low while its column is strobed
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && col[c] == 1'b0) row[r] = 1'b0;
   end

   // Every pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst === 1'b0 && key_valid !== 1'b0) begin
         mon_exp = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 5'h00;
         total++;
         assert ({key_valid, key_val} === mon_exp)
         else begin
            bad++;
            $error("FAIL pulse observed valid/val=%0h expected=%0h", {key_valid, key_val}, mon_exp);
         end
         $display("pulse: key_val=%0h expected=%0h", key_val, mon_exp[3:0]);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
      $display("check %s: observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // 1: reset state and column stepping
      clocks(3);
      rst = 1'b0;
      chk("rst_val", 32'(key_val), 32'h0);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_down", 32'(key_down), 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("col_step", 32'(col), 32'(col_seq[i]));
         clocks(4);
      end
      clocks(64);

      // 2: key 9 held
      pressed[9] = 1'b1;
      exp_q.push_back(4'h9);
      clocks(32);
      chk("k9_early_q", 32'(exp_q.size()), 32'd1);
      chk("k9_early_down", 32'(key_down), 32'h0);
      clocks(48);
      chk("k9_q", 32'(exp_q.size()), 32'd0);
      chk("k9_down", 32'(key_down), 32'h1);
      chk("k9_val", 32'(key_val), 32'h9);
`ifndef KEYPAD_REPEAT_EN
      clocks(160);
      chk("k9_hold_q", 32'(exp_q.size()), 32'd0);
      chk("k9_hold_down", 32'(key_down), 32'h1);
`endif

      // 5a: release
      pressed = 16'h0000;
      clocks(32);
      chk("rel_early_down", 32'(key_down), 32'h1);
      clocks(48);
      chk("rel_down", 32'(key_down), 32'h0);
      chk("rel_val", 32'(key_val), 32'h9);

      // 3: bounce then steady
      for (int i = 0; i < 5; i++) begin
         pressed[9] = (i % 2 == 0);
         clocks(16);
      end
      pressed[9] = 1'b1;
      exp_q.push_back(4'h9);
      clocks(80);
      chk("bounce_q", 32'(exp_q.size()), 32'd0);
      chk("bounce_down", 32'(key_down), 32'h1);
      chk("bounce_val", 32'(key_val), 32'h9);
      pressed = 16'h0000;
      clocks(96);
      chk("bounce_rel_down", 32'(key_down), 32'h0);

      // 4: ghost pair 9+6, then 6 released
      pressed[9] = 1'b1;
      pressed[6] = 1'b1;
      clocks(96);
      chk("ghost_down", 32'(key_down), 32'h0);
      chk("ghost_q", 32'(exp_q.size()), 32'd0);
      pressed[6] = 1'b0;
      exp_q.push_back(4'h9);
      clocks(32);
      chk("unghost_early_q", 32'(exp_q.size()), 32'd1);
      clocks(48);
      chk("unghost_q", 32'(exp_q.size()), 32'd0);
      chk("unghost_down", 32'(key_down), 32'h1);
      chk("unghost_val", 32'(key_val), 32'h9);

      // 5b: reset in the middle of debouncing key 5
      pressed = 16'h0000;
      clocks(96);
      chk("pre_rst_down", 32'(key_down), 32'h0);
      pressed[5] = 1'b1;
      clocks(24);
      rst = 1'b1;
      clocks(2);
      chk("midrst_col", 32'(col), 32'hE);
      chk("midrst_val", 32'(key_val), 32'h0);
      chk("midrst_down", 32'(key_down), 32'h0);
      chk("midrst_valid", 32'(key_valid), 32'h0);
      pressed = 16'h0000;
      rst = 1'b0;
      clocks(100);
      chk("post_rst_down", 32'(key_down), 32'h0);
      chk("post_rst_val", 32'(key_val), 32'h0);
      chk("post_rst_q", 32'(exp_q.size()), 32'd0);

`ifdef KEYPAD_REPEAT_EN
      // 6: auto-repeat on key F every 4 scans
      pressed[15] = 1'b1;
      exp_q.push_back(4'hF);
      clocks(80);
      chk("rep_first_q", 32'(exp_q.size()), 32'd0);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(4'hF);
         clocks(64);
         chk("rep_q", 32'(exp_q.size()), 32'd0);
         chk("rep_val", 32'(key_val), 32'hF);
      end
      pressed = 16'h0000;
      clocks(160);
      chk("rep_rel_down", 32'(key_down), 32'h0);
      chk("rep_rel_q", 32'(exp_q.size()), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
